// File: rtl/store_capture_fifo.sv
// store_capture_fifo: captures every store on the computer's data-memory bus into a FIFO stream.
// Define STORE_CAPTURE_TIMESTAMP_EN to add a per-entry cycle timestamp on out_time.
module store_capture_fifo #(
    parameter int unsigned N = 16,
    parameter int unsigned DEPTH = 8,
    parameter logic [N-1:0] DONE_ADDR = 'h0040,
    parameter logic [N-1:0] DONE_DATA = 'h0096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [N-1:0]               dataadr,
    input  logic [N-1:0]               writedata,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_addr,
    output logic [N-1:0]               out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                store_cnt,
    output logic [7:0]                 drop_cnt,
    output logic                       overflow,
    output logic                       done
`ifdef STORE_CAPTURE_TIMESTAMP_EN
    ,
    output logic [15:0]                out_time
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [N-1:0]  addr_mem [DEPTH];
    logic [N-1:0]  data_mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   level_q, level_d;
    logic [15:0]   store_cnt_q, store_cnt_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          overflow_q, overflow_d, done_q, done_d;
    logic          push, pop, accept, drop, match;

    // clear overrides both push and pop, so a store in a clear cycle is neither logged nor checked
    always_comb begin
        push        = memwrite & ~clear;
        pop         = (level_q != '0) & out_ready & ~clear;
        accept      = push & ((level_q != (AW+1)'(DEPTH)) | pop);
        drop        = push & ~accept;
        match       = push & (dataadr == DONE_ADDR) & (writedata == DONE_DATA);
        wr_d        = clear ? '0 : wr_q + AW'(accept);
        rd_d        = clear ? '0 : rd_q + AW'(pop);
        level_d     = clear ? '0 : level_q + (AW+1)'(accept) - (AW+1)'(pop);
        store_cnt_d = clear ? '0 : store_cnt_q + 16'(accept && store_cnt_q != '1);
        drop_cnt_d  = clear ? '0 : drop_cnt_q + 8'(drop && drop_cnt_q != '1);
        overflow_d  = ~clear & (overflow_q | drop);
        done_d      = ~clear & (done_q | match);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            store_cnt_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            level_q     <= level_d;
            store_cnt_q <= store_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_mem[wr_q] <= dataadr;
            data_mem[wr_q] <= writedata;
        end
    end

    assign out_valid = level_q != '0;
    assign out_addr  = out_valid ? addr_mem[rd_q] : '0;
    assign out_data  = out_valid ? data_mem[rd_q] : '0;
    assign level     = level_q;
    assign store_cnt = store_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

`ifdef STORE_CAPTURE_TIMESTAMP_EN
    logic [15:0] time_mem [DEPTH];
    logic [15:0] time_q, time_d;

    // free-running; deliberately untouched by clear
    always_comb time_d = time_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) time_q <= '0;
        else       time_q <= time_d;
    end

    always_ff @(posedge clk) begin
        if (accept) time_mem[wr_q] <= time_q;
    end

    assign out_time = out_valid ? time_mem[rd_q] : '0;
`endif
endmodule

// File: tb/tb_store_capture_fifo.sv
// tb_store_capture_fifo: randomized scoreboard bench for store_capture_fifo.
module tb_store_capture_fifo;
    localparam int DEPTH = 8;

    logic        clk = 0, reset = 1, memwrite = 0, clear = 0, out_ready = 0;
    logic [15:0] dataadr = 0, writedata = 0;
    logic        out_valid, overflow, done;
    logic [15:0] out_addr, out_data, store_cnt;
    logic [7:0]  drop_cnt;
    logic [3:0]  level;
`ifdef STORE_CAPTURE_TIMESTAMP_EN
    logic [15:0] out_time;
`endif

    store_capture_fifo dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .level(level), .store_cnt(store_cnt),
        .drop_cnt(drop_cnt), .overflow(overflow), .done(done)
`ifdef STORE_CAPTURE_TIMESTAMP_EN
        , .out_time(out_time)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [47:0] exp_q [$];
    int cur_lev, cur_sc, cur_dc, cur_ov, cur_done;
    int nxt_lev, nxt_sc, nxt_dc, nxt_ov, nxt_done;
    int tcount;

    task automatic chk(input string name, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_zero();
        exp_q.delete();
        nxt_lev = 0; nxt_sc = 0; nxt_dc = 0; nxt_ov = 0; nxt_done = 0;
        tcount = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_addrdata"}, {out_addr, out_data}, 0);
        chk({tag, "_counts"}, {store_cnt, drop_cnt}, 0);
        chk({tag, "_flags"}, {overflow, done}, 0);
    endtask

    // One clock: check the state left by the previous edge, then drive and predict the next edge
    task automatic cyc(input logic mw, input logic [15:0] a, input logic [15:0] d,
                       input logic rdy, input logic clr);
        bit pop, acc;
        @(posedge clk);
        tcount++;
        #1;
        cur_lev = nxt_lev; cur_sc = nxt_sc; cur_dc = nxt_dc; cur_ov = nxt_ov; cur_done = nxt_done;
        chk("level", level, cur_lev);
        chk("out_valid", out_valid, cur_lev != 0);
        chk("store_cnt", store_cnt, cur_sc);
        chk("drop_cnt", drop_cnt, cur_dc);
        chk("overflow", overflow, cur_ov);
        chk("done", done, cur_done);
        if (cur_lev == 0) chk("idle_head", {out_addr, out_data}, 0);
        memwrite = mw; dataadr = a; writedata = d; out_ready = rdy; clear = clr;
        if (clr) begin
            exp_q.delete();
            nxt_lev = 0; nxt_sc = 0; nxt_dc = 0; nxt_ov = 0; nxt_done = 0;
        end else begin
            pop = cur_lev > 0 && rdy;
            acc = mw && (cur_lev < DEPTH || pop);
            nxt_lev = cur_lev + int'(acc) - int'(pop);
            if (acc) begin
                exp_q.push_back({16'(tcount), a, d});
                if (nxt_sc < 65535) nxt_sc++;
            end
            if (mw && !acc) begin
                if (nxt_dc < 255) nxt_dc++;
                nxt_ov = 1;
            end
            if (mw && a == 16'h0040 && d == 16'h0096) nxt_done = 1;
        end
    endtask

    // Monitor: every accepted pop must present the oldest outstanding expected entry
    always @(negedge clk) begin
        logic [47:0] e;
        if (!reset && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("head", {out_addr, out_data}, e[31:0]);
`ifdef STORE_CAPTURE_TIMESTAMP_EN
                chk("out_time", out_time, e[47:32]);
`endif
            end
        end
    end

    task automatic release_reset();
        memwrite = 0; clear = 0; out_ready = 0;
        model_zero();
        @(negedge clk);
        #1 reset = 0;
    endtask

    task automatic mid_reset();
        #2 reset = 1;
        memwrite = 0; clear = 0; out_ready = 0;
        #1 check_outputs_zero("async_rst");
        @(posedge clk);
        release_reset();
    endtask

    initial begin
        reset = 1; memwrite = 1; dataadr = 16'h0040; writedata = 16'h0096; out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("rst_held");
        release_reset();
        repeat (3) cyc(0, 0, 0, 0, 0);

        cyc(1, 16'h0010, 16'h1234, 0, 0);
        cyc(1, 16'h0012, 16'hABCD, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("head_first", {out_addr, out_data}, {16'h0010, 16'h1234});
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < DEPTH + 3; i++) cyc(1, 16'(16'h0100 + i), 16'($urandom), 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 16'h0200, 16'h5555, 1, 0);
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 1, 0);

        cyc(1, 16'h0040, 16'h0095, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 16'h0040, 16'h0096, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(1, 16'h0040, 16'h0096, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 5; i++) cyc(1, 16'(16'h0300 + i), 16'(i * 7), 0, 0);
        cyc(0, 0, 0, 0, 0);
        mid_reset();
        repeat (2) cyc(0, 0, 0, 1, 0);

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) < 7,
                ($urandom_range(0, 3) == 0) ? 16'h0040 : 16'($urandom),
                ($urandom_range(0, 1) == 0) ? 16'h0096 : 16'($urandom),
                $urandom_range(0, 9) < ((i / 300) % 2 ? 8 : 3),
                $urandom_range(0, 59) == 0);
        repeat (DEPTH + 2) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
